// File: rtl/regfile_dump.sv
// Read-side sequencer for a 16 x 32 register file: walks an optionally wrapping index
// range through one read port and streams each register out as an indexed valid/ready beat.
module regfile_dump #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_sel,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last
);

  if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_num_regs
    $error("regfile_dump: NUM_REGS must equal 2**ADDR_W");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic              last_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] idx_q;

  // The index difference wraps naturally in ADDR_W bits, so last < first walks through 15 -> 0.
  logic [ADDR_W-1:0] span_diff_d;
  logic [ADDR_W:0]   span_d;
  logic              fetch_d;
  logic              accept_d;

  assign span_diff_d = last_idx - first_idx;
  assign span_d      = {1'b0, span_diff_d} + (ADDR_W+1)'(1);
  assign accept_d    = valid_q && out_ready;
  assign fetch_d     = (rem_q != '0) && (!valid_q || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q   <= first_idx;
            rem_q   <= span_d;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // A fetch refills the output slot in the same cycle the previous beat drains.
          if (fetch_d) begin
            data_q  <= rd_data;
            idx_q   <= ptr_q;
            valid_q <= 1'b1;
            last_q  <= (rem_q == (ADDR_W+1)'(1));
            ptr_q   <= ptr_q + ADDR_W'(1);
            rem_q   <= rem_q - (ADDR_W+1)'(1);
          end else if (accept_d) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
          if (accept_d && last_q) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_sel    = ptr_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a register-file model feeds rd_data, expected
// beats are queued at start and popped as the consumer accepts them.
module tb_regfile_dump;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] first_idx = '0;
  logic [ADDR_W-1:0] last_idx = '0;
  logic              busy, done, out_valid, out_last;
  logic [ADDR_W-1:0] rd_sel, out_idx;
  logic [DATA_W-1:0] rd_data, out_data;
  logic              out_ready = 1'b1;

  logic [DATA_W-1:0] regs [16];
  assign rd_data = regs[rd_sel];

  regfile_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .busy(busy), .done(done), .rd_sel(rd_sel), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int done_at  = 0;
  int done_cyc = -1;
  bit done_pending = 0;
  int ready_mode = 0;
  int ready_ph   = 0;
  beat_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Consumer ready: always 1, or the repeating pattern 1,0,0.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) begin
      out_ready = 1'b1;
    end else begin
      out_ready = (ready_ph == 0);
      ready_ph  = (ready_ph + 1) % 3;
    end
  end

  // Monitor: values seen at the negedge are what the next posedge will act on.
  bit                stall_prev = 0;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_idx, hold_sel;
  logic              hold_last;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, hold_data);
        chk("hold_idx", out_idx, hold_idx);
        chk("hold_last", out_last, hold_last);
        chk("hold_rd_sel", rd_sel, hold_sel);
      end
      if (done || (done_pending && cyc == done_at)) begin
        chk("done_pulse", done, done_pending && cyc == done_at);
        if (done) done_cyc = cyc;
      end
      if (done_pending && cyc >= done_at) done_pending = 0;
      if (out_valid && out_ready) begin
        beat_t e;
        n_acc++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("beat idx=%0d data=0x%08h last=%0b", out_idx, out_data, out_last);
          chk("beat_idx", out_idx, e.idx);
          chk("beat_data", out_data, e.data);
          chk("beat_last", out_last, e.last);
          if (e.last) begin
            done_pending = 1;
            done_at = cyc + 2;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_idx  = out_idx;
      hold_last = out_last;
      hold_sel  = rd_sel;
    end
  end

  task automatic drive_start(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                             input bit push);
    int n;
    @(posedge clk); #1;
    start = 1'b1; first_idx = f; last_idx = l;
    if (push) begin
      n = ((int'(l) - int'(f)) & 15) + 1;
      for (int k = 0; k < n; k++) begin
        beat_t b;
        b.idx  = ADDR_W'((int'(f) + k) & 15);
        b.data = regs[b.idx];
        b.last = (k == n - 1);
        exp_q.push_back(b);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !done_pending) break;
    end
    if (i == 300) chk({tag, "_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_acc(input int target);
    int i;
    for (i = 0; i < 300 && n_acc < target; i++) @(negedge clk);
    if (n_acc < target) chk("acc_timeout", n_acc, target);
  endtask

  initial begin
    int start_cyc;
    for (int i = 0; i < 16; i++) regs[i] = 32'hFFFF_FF00 + i;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_rd_sel", rd_sel, 0);
    rst = 1'b0;

    // Full dump 0..15 with latency and done-timing checks.
    drive_start(4'd0, 4'd15, 1);
    @(negedge clk);
    start_cyc = cyc;
    chk("lat_busy", busy, 1);
    chk("lat_rd_sel", rd_sel, 0);
    chk("lat_valid_n1", out_valid, 0);
    @(negedge clk);
    chk("lat_valid_n2", out_valid, 1);
    wait_finish("full");
    chk("done_latency", done_cyc - start_cyc, 18);

    for (int i = 0; i < 16; i++) regs[i] = $urandom;

    drive_start(4'd14, 4'd1, 1);
    wait_finish("wrap");

    drive_start(4'd5, 4'd5, 1);
    wait_finish("single");

    // Full dump under backpressure, wrapping from a nonzero start.
    ready_mode = 1;
    drive_start(4'd7, 4'd6, 1);
    wait_finish("stall");
    ready_mode = 0;

    // A second start mid-dump must be ignored.
    begin
      int base = n_acc;
      drive_start(4'd0, 4'd15, 1);
      wait_acc(base + 5);
      drive_start(4'd3, 4'd7, 0);
      wait_finish("ignore_start");
    end

    // Reset after the 3rd accepted beat drops the dump without a done pulse.
    begin
      int base = n_acc;
      drive_start(4'd0, 4'd15, 1);
      wait_acc(base + 3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      exp_q.delete();
      done_pending = 0;
      @(negedge clk);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rd_sel", rd_sel, 0);
      chk("mid_rst_done", done, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      drive_start(4'd9, 4'd12, 1);
      wait_finish("after_rst");
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
